keypad_input: RTL and testbench

// - Input-side counterpart of the bus-fed 7-segment display: scans a 4x4 hex keypad, debounces presses, and accumulates
//   the last two hex keys into an 8-bit value driven onto the CPU bus on an IN strobe.
// - Sits on the sys_clk domain beside display/clock; CPU control logic drives out_en/read_strobe, bus mux consumes bus_out/bus_oe.

---
 rtl/keypad_input.sv | 176 +++++++++++++++++
 tb/tb_keypad_input.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low hex keypad one column at a time,
// debounces presses and releases, and shifts the last two accepted keys into
// an 8-bit value that the CPU reads through the bus mux on an IN strobe.
// Optional feature macro: KEYPAD_CLEAR_KEY_EN turns key C into a clear key
// that zeroes the value and drops data_valid instead of shifting in.
module keypad_input #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  input  logic       out_en,
  input  logic       read_strobe,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       data_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [3:0]    rows_meta;
  logic [3:0]    rows_sync;
  logic [DW-1:0] dwell_cnt;
  logic [CW-1:0] deb_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    next_col;
  logic [1:0]    key_row;
  logic [1:0]    row_now;
  logic          single_low;
  logic          dwell_end;
  logic          commit;
  logic [3:0]    commit_key;
  logic [7:0]    value;

  // Two-flop synchroniser; idle keypad rows read as all high
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  // Dwell counter: each column is driven for SCAN_DIV cycles
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
    end else if (dwell_cnt == DWELL_LAST) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Decode the sampled rows; only exactly one low row counts as a key
  always_comb begin
    single_low = 1'b0;
    row_now    = 2'd0;
    case (rows_sync)
      4'b1110: begin single_low = 1'b1; row_now = 2'd0; end
      4'b1101: begin single_low = 1'b1; row_now = 2'd1; end
      4'b1011: begin single_low = 1'b1; row_now = 2'd2; end
      4'b0111: begin single_low = 1'b1; row_now = 2'd3; end
      default: begin single_low = 1'b0; row_now = 2'd0; end
    endcase
  end

  // Commit happens on the dwell end that completes the debounce count
  always_comb begin
    dwell_end  = (dwell_cnt == DWELL_LAST);
    next_col   = col_idx + 2'd1;
    commit_key = {row_now, col_idx};
    commit     = dwell_end && single_low &&
                 (((state == SCAN) && (DEBOUNCE_SCANS == 1)) ||
                  ((state == DEBOUNCE) && (row_now == key_row) && (deb_cnt == DEB_LAST)));
  end

  // Scan/debounce/hold sequencer with registered column drive
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      cols    <= 4'b1110;
      deb_cnt <= '0;
      key_row <= 2'd0;
    end else if (dwell_end) begin
      case (state)
        SCAN: begin
          if (single_low) begin
            key_row <= row_now;
            if (DEBOUNCE_SCANS == 1) begin
              deb_cnt <= '0;
              state   <= HELD;
            end else begin
              deb_cnt <= CW'(1);
              state   <= DEBOUNCE;
            end
          end else begin
            col_idx <= next_col;
            cols    <= ~(4'b0001 << next_col);
          end
        end
        DEBOUNCE: begin
          if (single_low && (row_now == key_row)) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              state   <= HELD;
            end else begin
              deb_cnt <= deb_cnt + CW'(1);
            end
          end else begin
            deb_cnt <= '0;
            state   <= SCAN;
            col_idx <= next_col;
            cols    <= ~(4'b0001 << next_col);
          end
        end
        HELD: begin
          if (rows_sync == 4'hF) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              state   <= SCAN;
              col_idx <= next_col;
              cols    <= ~(4'b0001 << next_col);
            end else begin
              deb_cnt <= deb_cnt + CW'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: begin
          deb_cnt <= '0;
          state   <= SCAN;
        end
      endcase
    end
  end

  // Value shift register and data_valid handshake; a commit beats read_strobe
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      value      <= 8'h00;
      data_valid <= 1'b0;
    end else if (commit) begin
`ifdef KEYPAD_CLEAR_KEY_EN
      if (commit_key == 4'hC) begin
        value      <= 8'h00;
        data_valid <= 1'b0;
      end else begin
        value      <= {value[3:0], commit_key};
        data_valid <= 1'b1;
      end
`else
      value      <= {value[3:0], commit_key};
      data_valid <= 1'b1;
`endif
    end else if (read_strobe) begin
      data_valid <= 1'b0;
    end
  end

  assign bus_out = out_en ? value : 8'h00;
  assign bus_oe  = out_en;

endmodule

// File: tb/tb_keypad_input.sv
// tb_keypad_input: directed bench for keypad_input with SCAN_DIV=4 and
// DEBOUNCE_SCANS=2. A small keypad model pulls a row low while its column
// is driven. Expected values follow KEYPAD_CLEAR_KEY_EN when it is defined.
module tb_keypad_input;

  logic       sys_clk;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       out_en;
  logic       read_strobe;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       data_valid;

  logic       key_down;
  logic [3:0] key_code;
  logic       ghost_en;
  logic       found;
  int         pass_count;
  int         total_checks;
  logic [3:0] rot_exp [5];

  keypad_input #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .rows(rows),
    .cols(cols),
    .out_en(out_en),
    .read_strobe(read_strobe),
    .bus_out(bus_out),
    .bus_oe(bus_oe),
    .data_valid(data_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Keypad model: the pressed key shorts its row low only while its column is driven
  assign rows = ghost_en ? ((cols == 4'b1110) ? 4'b1010 : 4'hF)
              : (key_down && (cols[key_code[1:0]] == 1'b0)) ? ~(4'b0001 << key_code[3:2])
              : 4'hF;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    else
      pass_count++;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] expected);
    out_en = 1'b1;
    #1;
    checkOutput(tag, {24'h0, bus_out}, {24'h0, expected});
    out_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic press, input logic [3:0] code, input int cycles);
    key_down = press;
    key_code = code;
    repeat (cycles) @(negedge sys_clk);
  endtask

  task automatic waitForCol(input logic [3:0] target, output logic hit);
    logic [3:0] prev;
    prev = cols;
    hit  = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge sys_clk);
      if (cols == target && prev != target) hit = 1'b1;
      prev = cols;
    end
  endtask

  initial begin
    pass_count   = 0;
    total_checks = 0;
    rst          = 1'b0;
    out_en       = 1'b0;
    read_strobe  = 1'b0;
    key_down     = 1'b0;
    key_code     = 4'h0;
    ghost_en     = 1'b0;
    rot_exp[0] = 4'b1110; rot_exp[1] = 4'b1101; rot_exp[2] = 4'b1011;
    rot_exp[3] = 4'b0111; rot_exp[4] = 4'b1110;
    $display("[TB] start");

    repeat (3) @(negedge sys_clk);
    checkOutput("rst_cols", cols, 4'b1110);
    checkOutput("rst_dv", data_valid, 1'b0);
    checkOutput("rst_oe", bus_oe, 1'b0);
    checkOutput("rst_bus", bus_out, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rotate_%0d", i), cols, rot_exp[i]);
      repeat (4) @(negedge sys_clk);
    end

    applyStimulus(1'b1, 4'h6, 40);
    checkValue("entry_06", 8'h06);
    checkOutput("entry_dv1", data_valid, 1'b1);
    applyStimulus(1'b0, 4'h6, 20);
    applyStimulus(1'b1, 4'hA, 40);
    checkValue("entry_6a", 8'h6A);
    checkOutput("entry_dv2", data_valid, 1'b1);
    out_en = 1'b1;
    #1;
    checkOutput("entry_oe_on", bus_oe, 1'b1);
    out_en = 1'b0;
    #1;
    checkOutput("entry_oe_off", bus_oe, 1'b0);
    checkOutput("entry_bus_off", bus_out, 8'h00);
    applyStimulus(1'b0, 4'hA, 20);

    waitForCol(4'b1011, found);
    checkOutput("bounce_col_wait", found, 1'b1);
    applyStimulus(1'b1, 4'h6, 4);
    applyStimulus(1'b0, 4'h6, 5);
    checkOutput("bounce_cols", cols, 4'b0111);
    checkValue("bounce_value", 8'h6A);

    applyStimulus(1'b1, 4'h3, 80);
    checkValue("hold_once", 8'hA3);
    applyStimulus(1'b0, 4'h3, 20);
    applyStimulus(1'b1, 4'h3, 40);
    checkValue("hold_again", 8'h33);
    applyStimulus(1'b0, 4'h3, 20);

    read_strobe = 1'b1;
    @(negedge sys_clk);
    read_strobe = 1'b0;
    checkOutput("hs_read_clear", data_valid, 1'b0);
    checkValue("hs_stale", 8'h33);
    checkOutput("hs_outen_keeps_dv", data_valid, 1'b0);
    waitForCol(4'b1101, found);
    checkOutput("hs_col_wait", found, 1'b1);
    applyStimulus(1'b1, 4'h5, 7);
    checkOutput("hs_pre_commit", data_valid, 1'b0);
    read_strobe = 1'b1;
    @(negedge sys_clk);
    read_strobe = 1'b0;
    checkOutput("hs_commit_wins", data_valid, 1'b1);
    checkValue("hs_value", 8'h35);
    applyStimulus(1'b0, 4'h5, 20);

    read_strobe = 1'b1;
    @(negedge sys_clk);
    read_strobe = 1'b0;
    ghost_en = 1'b1;
    repeat (40) @(negedge sys_clk);
    ghost_en = 1'b0;
    checkOutput("ghost_dv", data_valid, 1'b0);
    checkValue("ghost_value", 8'h35);
    repeat (20) @(negedge sys_clk);

    applyStimulus(1'b1, 4'h6, 40);
    applyStimulus(1'b0, 4'h6, 20);
    applyStimulus(1'b1, 4'hA, 40);
    applyStimulus(1'b0, 4'hA, 20);
    checkValue("clear_pre", 8'h6A);
    applyStimulus(1'b1, 4'hC, 40);
`ifdef KEYPAD_CLEAR_KEY_EN
    checkValue("clear_value", 8'h00);
    checkOutput("clear_dv", data_valid, 1'b0);
`else
    checkValue("keyc_value", 8'hAC);
    checkOutput("keyc_dv", data_valid, 1'b1);
`endif
    applyStimulus(1'b0, 4'hC, 20);

    applyStimulus(1'b1, 4'h9, 40);
`ifdef KEYPAD_CLEAR_KEY_EN
    checkValue("midhold_pre", 8'h09);
`else
    checkValue("midhold_pre", 8'hC9);
`endif
    @(negedge sys_clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_cols", cols, 4'b1110);
    checkOutput("midrst_dv", data_valid, 1'b0);
    checkOutput("midrst_oe", bus_oe, 1'b0);
    checkOutput("midrst_bus", bus_out, 8'h00);
    checkValue("midrst_value", 8'h00);
    @(negedge sys_clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'h9, 40);
    checkValue("fresh_press", 8'h09);
    checkOutput("fresh_dv", data_valid, 1'b1);
    applyStimulus(1'b0, 4'h9, 20);

    $display("%0d/%0d checks passed", pass_count, total_checks);
    $finish;
  end

endmodule
